i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h50, meaning the 7-bit address this slave answers to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchroniser flops on sclk and sda_in (minimum 2).
REQ-003 Port clk, input, 1, system clock; SHALL be at least 8x the sclk frequency.
REQ-004 Port rst, input, 1, synchronous active-low reset.
REQ-005 Port sclk, input, 1, I2C clock from the master.
REQ-006 Port sda_in, input, 1, I2C data as driven by the master.
REQ-007 Port sda_out, output, 1, slave data drive; 1 = released, 0 = pull low.
REQ-008 Port tx_data, input, 8, byte returned on a master read; held stable by upstream while tx_load is pending.
REQ-009 Port tx_load, output, 1, one-cycle pulse when tx_data is captured into the shift register.
REQ-010 Port rx_data, output, 8, last byte written by the master.
REQ-011 Port rx_valid, output, 1, one-cycle pulse when rx_data is updated.
REQ-012 Port state, output, 3, current FSM state encoding.
REQ-013 Port busy, output, 1, high from an address match until STOP or NACK.

Function
REQ-014 sclk and sda_in SHALL pass through SYNC_STAGES flops; rise/fall events SHALL be detected one cycle after sync, giving a fixed latency of SYNC_STAGES+1 clk from pin to event.
REQ-015 START (sda fall while sclk high) SHALL move the FSM to ADDR from any state, including mid-byte (repeated start), and clear the bit counter.
REQ-016 STOP (sda rise while sclk high) SHALL move the FSM to IDLE from any state and release sda_out on the same cycle.
REQ-017 States: IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6.
REQ-018 Data SHALL be sampled on sclk rise and sda_out SHALL change only on sclk fall; all bytes are MSB first.
REQ-019 ADDR: 7 address bits plus rw bit; on mismatch after the 8th bit -> IDLE, no ACK, and the slave ignores the bus until the next START.
REQ-020 On match: drive sda_out=0 from the 8th sclk fall to the 9th sclk fall (ADDR_ACK) and assert busy.
REQ-021 rw=0: ADDR_ACK -> RX; after 8 bits, rx_data and rx_valid update in the cycle following the 8th rise event, then RX_ACK drives ACK for the 9th bit, then -> RX.
REQ-022 rw=1: tx_load pulses and tx_data is captured on the 9th sclk fall of ADDR_ACK; MSB driven immediately -> TX.
REQ-023 After 8 TX bits the slave SHALL release sda_out and enter TX_ACK; on the 9th rise, master ACK (0) -> reload via tx_load -> TX, NACK (1) -> IDLE with busy cleared.
REQ-024 The bit counter SHALL be 3 bits, wrapping 7->0 only on byte completion.
REQ-025 Simultaneous START and sclk-edge events in one cycle: START SHALL win.

Reset
REQ-026 With rst=0 at a clk rise, next cycle: state=IDLE, sda_out=1, tx_load=0, rx_valid=0, rx_data=8'h00, busy=0, counters=0, and synchroniser flops=1.
REQ-027 Reset mid-transfer SHALL abort without further bus drive; the first transfer after reset requires a fresh START.

Configuration
REQ-028 With I2C_SLAVE_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow the synchroniser on both lines, adding exactly 1 clk latency; without it, synchronised signals SHALL be used directly.

Structure
REQ-029 Package i2c_pkg SHALL hold the state encodings, I2C_ADDR_W=7, I2C_BYTE_W=8, and ACK=1'b0 / NACK=1'b1 constants, shared with the master.
REQ-030 Sub-module i2c_sync_edge (synchroniser, optional filter, rise/fall outputs) SHALL be instantiated twice, once for sclk and once for sda.

Verification
REQ-031 Write to 7'h50, byte 8'ha6 -> ACK on both 9th bits, rx_data=8'ha6, rx_valid pulses once.
REQ-032 Read from 7'h50 with tx_data=8'hf6, master NACK -> bus sees 11110110, tx_load pulses once, returns to IDLE.
REQ-033 Read 2 bytes (8'hf6, then 8'h3c) with master ACK then NACK -> tx_load pulses twice, busy drops after the NACK.
REQ-034 Address 7'h51 -> sda_out stays 1 for the whole transfer, state returns to IDLE, no rx_valid.
REQ-035 Repeated START after 4 data bits, then write to 7'h50 with 8'h11 -> rx_data=8'h11, no partial-byte rx_valid.
REQ-036 rst=0 asserted during RX bit 5 -> next cycle all outputs at reset values; a subsequent full write still succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants and slave FSM state encodings
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX       = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX       = 3'd5,
        ST_TX_ACK   = 3'd6
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - line synchroniser, optional majority filter (I2C_SLAVE_GLITCH_FILTER_EN), edge events
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lvl;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    // Metastability chain; idles high like a released bus line
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic r_old;
    logic r_filt;

    // Majority of the three most recent synchronised samples, one register deep
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_old  <= 1'b1;
            r_filt <= 1'b1;
        end else begin
            r_old  <= r_sync[SYNC_STAGES-1];
            r_filt <= (r_sync[SYNC_STAGES-2] & r_sync[SYNC_STAGES-1]) |
                      (r_sync[SYNC_STAGES-2] & r_old) |
                      (r_sync[SYNC_STAGES-1] & r_old);
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync[SYNC_STAGES-1];
`endif

    // Registered edge events; o_level is delayed to stay aligned with them
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= w_lvl;
            r_rise <= w_lvl & ~r_prev;
            r_fall <= ~w_lvl & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C slave with byte rx/tx handshake; glitch filter via I2C_SLAVE_GLITCH_FILTER_EN
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  sda_in,
    output logic                  sda_out,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_load,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic [2:0]            state,
    output logic                  busy
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk    (clk),
        .rst    (rst),
        .i_din  (sclk),
        .o_level(w_scl_lvl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk    (clk),
        .rst    (rst),
        .i_din  (sda_in),
        .o_level(w_sda_lvl),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;

    i2c_state_e            r_state, w_state_nxt;
    logic [2:0]            r_bit_cnt, w_cnt_nxt;
    logic [I2C_BYTE_W-1:0] r_shift, w_shift_nxt;
    logic                  r_sda_out, w_sda_nxt;
    logic                  r_rw, w_rw_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_byte_done, w_done_nxt;
    logic [I2C_BYTE_W-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  r_tx_load, w_tx_load_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= '0;
            r_sda_out   <= 1'b1;
            r_rw        <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_load   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_sda_out   <= w_sda_nxt;
            r_rw        <= w_rw_nxt;
            r_busy      <= w_busy_nxt;
            r_byte_done <= w_done_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_tx_load   <= w_tx_load_nxt;
        end
    end

    // Next state: bus conditions override edges; bits sampled on rise, sda changed on fall
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_sda_nxt      = r_sda_out;
        w_rw_nxt       = r_rw;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_byte_done;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_load_nxt  = 1'b0;

        if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_sda_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = 3'd0;
            w_done_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_sda_nxt   = 1'b1;
            w_cnt_nxt   = 3'd0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[I2C_BYTE_W-2:0], w_sda_lvl};
                        if (r_bit_cnt == 3'd7) begin
                            w_cnt_nxt = 3'd0;
                            // The first seven bits now sit in r_shift[6:0]; the bit arriving is rw
                            if (r_shift[I2C_ADDR_W-1:0] == SLAVE_ADDR) begin
                                w_busy_nxt = 1'b1;
                                w_done_nxt = 1'b1;
                                w_rw_nxt   = w_sda_lvl;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_busy_nxt  = 1'b0;
                            end
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_done_nxt  = 1'b0;
                        w_sda_nxt   = ACK;
                        w_state_nxt = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            w_shift_nxt   = tx_data;
                            w_tx_load_nxt = 1'b1;
                            w_sda_nxt     = tx_data[I2C_BYTE_W-1];
                            w_state_nxt   = ST_TX;
                        end else begin
                            w_sda_nxt   = 1'b1;
                            w_state_nxt = ST_RX;
                        end
                    end
                end
                ST_RX: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[I2C_BYTE_W-2:0], w_sda_lvl};
                        if (r_bit_cnt == 3'd7) begin
                            w_cnt_nxt      = 3'd0;
                            w_rx_data_nxt  = {r_shift[I2C_BYTE_W-2:0], w_sda_lvl};
                            w_rx_valid_nxt = 1'b1;
                            w_done_nxt     = 1'b1;
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_done_nxt  = 1'b0;
                        w_sda_nxt   = ACK;
                        w_state_nxt = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_nxt   = 1'b1;
                        w_state_nxt = ST_RX;
                    end
                end
                ST_TX: begin
                    if (w_scl_rise) begin
                        // Master has sampled shift[7]; advance so the next fall drives the following bit
                        w_shift_nxt = {r_shift[I2C_BYTE_W-2:0], 1'b0};
                        if (r_bit_cnt == 3'd7) begin
                            w_cnt_nxt  = 3'd0;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end else if (w_scl_fall) begin
                        if (r_byte_done) begin
                            w_done_nxt  = 1'b0;
                            w_sda_nxt   = 1'b1;
                            w_state_nxt = ST_TX_ACK;
                        end else begin
                            w_sda_nxt = r_shift[I2C_BYTE_W-1];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda_lvl == ACK) begin
                            w_shift_nxt   = tx_data;
                            w_tx_load_nxt = 1'b1;
                            w_state_nxt   = ST_TX;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign sda_out  = r_sda_out;
    assign tx_load  = r_tx_load;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign state    = r_state;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - randomized bus-level bench for i2c_slave against a transaction model
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b1;
    logic       sda_in = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_out, tx_load, rx_valid, busy;
    logic [7:0] rx_data;
    logic [2:0] state;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .sda_in  (sda_in),
        .sda_out (sda_out),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .state   (state),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int q = 4;
    int cyc = 0;

    logic       g_chk = 1'b0;
    int         g_exp_sda = -1;
    int         g_exp_st = -1;
    int         g_exp_busy = -1;
    logic [7:0] exp_rx[$];
    logic [7:0] g_rd[4];
    logic [7:0] g_seen[4];
    int         n_load = 0;
    int         n_rx = 0;
    int         n_low = 0;
    int         g_base = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: bus-phase expectations, received bytes, load events, tx_data supply
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 90000) begin
                $display("FAIL watchdog actual=%0d required=below 90000", cyc);
                $fatal(1, "cycle budget exhausted");
            end
            if (rst) begin
                if (g_chk) begin
                    if (g_exp_sda >= 0)  check("sda_out", 32'(sda_out), g_exp_sda);
                    if (g_exp_st >= 0)   check("state", 32'(state), g_exp_st);
                    if (g_exp_busy >= 0) check("busy", 32'(busy), g_exp_busy);
                end
                if (sda_out == 1'b0) n_low++;
                if (rx_valid) begin
                    n_rx++;
                    if (exp_rx.size() == 0) check("rx_valid_unexpected", 32'd1, 32'd0);
                    else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                end
                if (tx_load) n_load++;
            end
            idx = n_load - g_base;
            tx_data = (idx >= 0 && idx < 4) ? g_rd[idx] : 8'h00;
        end
    end

    // One bit slot: master drives during low, expectations hold in the settled part of the high phase
    task automatic clock_bit(input logic drv, input int e_sda, input int e_st, input int e_busy,
                             output logic seen);
        wait_clk(q);
        sda_in = drv;
        wait_clk(q);
        sclk = 1'b1;
        wait_clk(6);
        g_exp_sda  = e_sda;
        g_exp_st   = e_st;
        g_exp_busy = e_busy;
        g_chk      = 1'b1;
        wait_clk(2 * q - 6);
        seen  = sda_in & sda_out;
        g_chk = 1'b0;
        sclk  = 1'b0;
    endtask

    task automatic do_start();
        if (sclk == 1'b0) begin
            wait_clk(q);
            sda_in = 1'b1;
            wait_clk(q);
            sclk = 1'b1;
        end
        wait_clk(q);
        sda_in = 1'b0;
        wait_clk(q);
        sclk = 1'b0;
    endtask

    task automatic do_stop();
        wait_clk(q);
        sda_in = 1'b0;
        wait_clk(q);
        sclk = 1'b1;
        wait_clk(q);
        sda_in = 1'b1;
        wait_clk(q);
    endtask

    task automatic check_idle();
        wait_clk(6);
        check("idle_state", 32'(state), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sda", 32'(sda_out), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_state", 32'(state), 32'd0);
        check("rst_sda", 32'(sda_out), 32'd1);
        check("rst_tx_load", 32'(tx_load), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic addr_phase(input logic [6:0] addr, input logic rw, input logic match);
        logic [7:0] b;
        logic s;
        b = {addr, rw};
        for (int i = 0; i < 8; i++)
            clock_bit(b[7-i], 1, (i < 7) ? 1 : (match ? 1 : 0), (i < 7) ? -1 : (match ? 1 : 0), s);
        clock_bit(1'b1, match ? 0 : 1, match ? 2 : 0, match ? 1 : 0, s);
    endtask

    // Full transaction: expected bus behaviour derived from address match, direction and bytes
    task automatic do_xfer(input logic [6:0] addr, input logic rw, input int n);
        logic match;
        logic s;
        logic d;
        int   base_rx;
        int   base_load;
        match     = (addr == 7'h50);
        g_base    = n_load;
        base_load = n_load;
        base_rx   = n_rx;
        do_start();
        addr_phase(addr, rw, match);
        for (int j = 0; j < n; j++) begin
            if (!match) begin
                for (int i = 0; i < 9; i++) begin
                    d = 1'b1;
                    if (i < 8 && !rw) d = g_rd[j][7-i];
                    clock_bit(d, 1, 0, 0, s);
                end
            end else if (!rw) begin
                exp_rx.push_back(g_rd[j]);
                for (int i = 0; i < 8; i++) clock_bit(g_rd[j][7-i], 1, 3, 1, s);
                clock_bit(1'b1, 0, 4, 1, s);
            end else begin
                for (int i = 0; i < 8; i++) begin
                    clock_bit(1'b1, g_rd[j][7-i], 5, 1, s);
                    g_seen[j][7-i] = s;
                end
                clock_bit((j == n - 1) ? 1'b1 : 1'b0, 1, -1, -1, s);
            end
        end
        if (match && rw) begin
            check("busy_after_nack", 32'(busy), 32'd0);
            check("state_after_nack", 32'(state), 32'd0);
            for (int j = 0; j < n; j++) check("read_byte", 32'(g_seen[j]), 32'(g_rd[j]));
        end
        do_stop();
        check_idle();
        check("rx_left", 32'(exp_rx.size()), 32'd0);
        exp_rx.delete();
        check("tx_load_count", 32'(n_load - base_load), (match && rw) ? 32'(n) : 32'd0);
        check("rx_count", 32'(n_rx - base_rx), (match && !rw) ? 32'(n) : 32'd0);
    endtask

    initial begin
        logic [6:0] a;
        logic       s;
        int         b0;

        rst = 1'b0;
        wait_clk(3);
        check_reset_outputs();
        rst = 1'b1;
        wait_clk(4);

        // Write a6 to the matching address
        g_rd[0] = 8'ha6;
        do_xfer(7'h50, 1'b0, 1);
        check("write_a6", 32'(rx_data), 32'h0a6);

        // Single byte read, master NACK
        g_rd[0] = 8'hf6;
        b0 = n_load;
        do_xfer(7'h50, 1'b1, 1);
        check("bus_read_f6", 32'(g_seen[0]), 32'h0f6);
        check("loads_one", 32'(n_load - b0), 32'd1);

        // Two byte read, ACK then NACK
        g_rd[0] = 8'hf6;
        g_rd[1] = 8'h3c;
        b0 = n_load;
        do_xfer(7'h50, 1'b1, 2);
        check("bus_read_3c", 32'(g_seen[1]), 32'h03c);
        check("loads_two", 32'(n_load - b0), 32'd2);

        // Foreign address: the slave must never pull the line
        g_rd[0] = 8'h00;
        b0 = n_low;
        do_xfer(7'h51, 1'b0, 1);
        check("foreign_no_pull", 32'(n_low - b0), 32'd0);

        // Repeated START after four data bits, then a complete write
        b0 = n_rx;
        do_start();
        addr_phase(7'h50, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), 1, 3, 1, s);
        g_rd[0] = 8'h11;
        do_xfer(7'h50, 1'b0, 1);
        check("rstart_data", 32'(rx_data), 32'h011);
        check("rstart_rx_once", 32'(n_rx - b0), 32'd1);

        // Reset asserted in the high phase of the fifth data bit
        do_start();
        addr_phase(7'h50, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), 1, 3, 1, s);
        wait_clk(q);
        sda_in = 1'($urandom_range(0, 1));
        wait_clk(q);
        sclk = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        check_reset_outputs();
        rst = 1'b1;
        wait_clk(q);
        sclk = 1'b0;
        do_stop();
        check_idle();
        g_rd[0] = 8'($urandom);
        do_xfer(7'h50, 1'b0, 1);
        check("post_reset_write", 32'(rx_data), 32'(g_rd[0]));

        // Randomized transactions
        for (int t = 0; t < 14; t++) begin
            q = $urandom_range(4, 7);
            a = 7'h50;
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom);
                if (a == 7'h50) a = 7'h51;
            end
            for (int j = 0; j < 4; j++) g_rd[j] = 8'($urandom);
            do_xfer(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
